// File: rtl/bl_pkg.sv
// bl_pkg: shared types, constants and helpers for the backlight level generator.
//   blState_t   : frame-processing FSM states (ACCUM, DIVIDE, FILTER)
//   Y_W         : brightness width
//   max3        : pixel brightness, the largest of R, G and B
//   target_calc : weighted peak/mean backlight target with a lower clamp
package bl_pkg;

  localparam int Y_W = 8;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    DIVIDE = 2'd1,
    FILTER = 2'd2
  } blState_t;

  function automatic logic [Y_W-1:0] max3(input logic [23:0] pix);
    logic [Y_W-1:0] m;
    m = pix[23:16];
    if (pix[15:8] > m) m = pix[15:8];
    if (pix[7:0] > m) m = pix[7:0];
    return m;
  endfunction

  // (3*max + avg + 2) >> 2; the 10-bit sum cannot overflow (3*255+255+2 = 1022).
  function automatic logic [Y_W-1:0] target_calc(input logic [Y_W-1:0] frameMax,
                                                 input logic [Y_W-1:0] frameAvg,
                                                 input logic [Y_W-1:0] minLevel);
    logic [9:0] acc;
    logic [Y_W-1:0] t;
    acc = {2'b00, frameMax} + {1'b0, frameMax, 1'b0} + {2'b00, frameAvg} + 10'd2;
    t = acc[9:2];
    return (t < minLevel) ? minLevel : t;
  endfunction

endpackage

// File: rtl/bl_serial_div.sv
// bl_serial_div: restoring divider producing an 8-bit quotient, one bit per clock.
//   clk, rstN  : clock, asynchronous active-low reset
//   start      : load dividend/divisor (ignored while busy)
//   dividend   : CNT_W+8 bits; divisor: CNT_W bits
//   busy       : iteration in progress
//   done       : high during the final iteration; quotient is valid from the next cycle
//   quotient   : floor(dividend/divisor), caller guarantees it is < 256
module bl_serial_div
  import bl_pkg::*;
#(
  parameter int CNT_W = 22
) (
  input  logic               clk,
  input  logic               rstN,
  input  logic               start,
  input  logic [CNT_W+7:0]   dividend,
  input  logic [CNT_W-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic [Y_W-1:0]     quotient
);

  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] divisorR;
  logic [Y_W-1:0]   lowBits;
  logic [2:0]       stepCnt;
  logic [CNT_W:0]   trial;
  logic [CNT_W:0]   diff;

  // Quotient < 256 means dividend>>8 < divisor, so the upper dividend bits
  // seed the remainder directly and only the low 8 bits need iterating.
  always_comb begin
    trial = {rem, lowBits[Y_W-1]};
    diff  = trial - {1'b0, divisorR};
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rem      <= '0;
      divisorR <= '0;
      lowBits  <= '0;
      quotient <= '0;
      stepCnt  <= '0;
      busy     <= 1'b0;
    end else if (start && !busy) begin
      rem      <= dividend[CNT_W+7:8];
      lowBits  <= dividend[7:0];
      divisorR <= divisor;
      stepCnt  <= '0;
      busy     <= 1'b1;
    end else if (busy) begin
      // diff MSB set means trial < divisor: keep trial, quotient bit 0.
      rem      <= diff[CNT_W] ? trial[CNT_W-1:0] : diff[CNT_W-1:0];
      quotient <= {quotient[Y_W-2:0], ~diff[CNT_W]};
      lowBits  <= {lowBits[Y_W-2:0], 1'b0};
      stepCnt  <= stepCnt + 3'd1;
      if (stepCnt == 3'd7) busy <= 1'b0;
    end
  end

  assign done = busy && (stepCnt == 3'd7);

endmodule

// File: rtl/backlight_level_gen.sv
// backlight_level_gen: per-frame dynamic backlight controller.
// Measures peak and mean brightness of each frame, derives a clamped target
// level, optionally smooths it (define BL_IIR_EN for IIR smoothing, otherwise
// the clamped target is used directly) and drives a glitch-free PWM output.
//   iODCK            : pixel clock
//   iSW1pass0nothing : asynchronous active-low reset
//   iDE, iVSYNC, iQE : video stream (pixel R=[23:16], G=[15:8], B=[7:0])
//   oBL_LEVEL        : current backlight level
//   oLEVEL_VALID     : one-cycle pulse when oBL_LEVEL updates
//   oFRAME_MAX/AVG   : peak/mean brightness of the last completed frame
//   oBL_PWM          : backlight PWM
module backlight_level_gen
  import bl_pkg::*;
#(
  parameter int CNT_W      = 22,
  parameter int MIN_LEVEL  = 16,
  parameter int INIT_LEVEL = 255,
  parameter int IIR_SHIFT  = 2,
  parameter int PWM_DIV    = 64
) (
  input  logic        iODCK,
  input  logic        iSW1pass0nothing,
  input  logic        iDE,
  input  logic        iVSYNC,
  input  logic [23:0] iQE,
  output logic [7:0]  oBL_LEVEL,
  output logic        oLEVEL_VALID,
  output logic [7:0]  oFRAME_MAX,
  output logic [7:0]  oFRAME_AVG,
  output logic        oBL_PWM
);

  localparam int SUM_W = CNT_W + 8;
  localparam int PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

  logic             vsync_p0, vsync_p1, frameEdge;
  logic [Y_W-1:0]   pixY, maxAcc, snapMax;
  logic [SUM_W-1:0] sumAcc;
  logic [CNT_W-1:0] cntAcc;
  logic             snapZero, acceptEdge;
  blState_t         state, stateNext;
  logic             divStart, divBusy, divDone;
  logic [Y_W-1:0]   divQuot, avgVal, targetVal, levelNext;
  logic [PRE_W-1:0] preCnt;
  logic [7:0]       phase, duty;
  logic             preWrap;

  // Signed step toward target; nudges by 1 when the shift alone would stall.
  function automatic logic [7:0] iirStep(input logic [7:0] level, input logic [7:0] target);
    logic signed [8:0] diff, stepVal, sum;
    diff    = $signed({1'b0, target}) - $signed({1'b0, level});
    stepVal = diff >>> IIR_SHIFT;
    if (diff != '0 && stepVal == '0) stepVal = diff[8] ? -9'sd1 : 9'sd1;
    sum = $signed({1'b0, level}) + stepVal;
    return sum[7:0];
  endfunction

  // --- stage p0/p1: registered VSYNC and rising-edge detect
  always_ff @(posedge iODCK or negedge iSW1pass0nothing) begin
    if (!iSW1pass0nothing) begin
      vsync_p0 <= 1'b0;
      vsync_p1 <= 1'b0;
    end else begin
      vsync_p0 <= iVSYNC;
      vsync_p1 <= vsync_p0;
    end
  end

  assign frameEdge = vsync_p0 && !vsync_p1;
  assign pixY      = max3(iQE);

  // --- stage: frame accumulators (a pixel on the edge cycle starts the new frame)
  always_ff @(posedge iODCK or negedge iSW1pass0nothing) begin
    if (!iSW1pass0nothing) begin
      maxAcc <= '0;
      sumAcc <= '0;
      cntAcc <= '0;
    end else if (frameEdge) begin
      maxAcc <= iDE ? pixY : '0;
      sumAcc <= iDE ? SUM_W'(pixY) : '0;
      cntAcc <= iDE ? CNT_W'(1) : '0;
    end else if (iDE) begin
      if (pixY > maxAcc) maxAcc <= pixY;
      if (cntAcc != '1) begin
        sumAcc <= sumAcc + SUM_W'(pixY);
        cntAcc <= cntAcc + CNT_W'(1);
      end
    end
  end

  // --- stage: frame FSM; edges outside ACCUM are dropped
  always_ff @(posedge iODCK or negedge iSW1pass0nothing) begin
    if (!iSW1pass0nothing) state <= ACCUM;
    else                   state <= stateNext;
  end

  always_comb begin
    stateNext  = state;
    divStart   = 1'b0;
    acceptEdge = 1'b0;
    case (state)
      ACCUM: begin
        if (frameEdge) begin
          acceptEdge = 1'b1;
          if (cntAcc != '0 && !divBusy) begin
            divStart  = 1'b1;
            stateNext = DIVIDE;
          end else begin
            stateNext = FILTER;
          end
        end
      end
      DIVIDE:  if (divDone) stateNext = FILTER;
      FILTER:  stateNext = ACCUM;
      default: stateNext = ACCUM;
    endcase
  end

  always_ff @(posedge iODCK or negedge iSW1pass0nothing) begin
    if (!iSW1pass0nothing) begin
      snapMax  <= '0;
      snapZero <= 1'b1;
    end else if (acceptEdge) begin
      snapMax  <= maxAcc;
      snapZero <= (cntAcc == '0);
    end
  end

  // The divider captures the live sum/count at the accepted edge.
  bl_serial_div #(.CNT_W(CNT_W)) uDiv (
    .clk      (iODCK),
    .rstN     (iSW1pass0nothing),
    .start    (divStart),
    .dividend (sumAcc),
    .divisor  (cntAcc),
    .busy     (divBusy),
    .done     (divDone),
    .quotient (divQuot)
  );

  // --- stage: FILTER, target and level update
  always_comb begin
    avgVal    = snapZero ? '0 : divQuot;
    targetVal = target_calc(snapMax, avgVal, 8'(MIN_LEVEL));
`ifdef BL_IIR_EN
    levelNext = iirStep(oBL_LEVEL, targetVal);
`else
    levelNext = targetVal;
`endif
  end

  always_ff @(posedge iODCK or negedge iSW1pass0nothing) begin
    if (!iSW1pass0nothing) begin
      oBL_LEVEL    <= 8'(INIT_LEVEL);
      oFRAME_MAX   <= '0;
      oFRAME_AVG   <= '0;
      oLEVEL_VALID <= 1'b0;
    end else begin
      oLEVEL_VALID <= (state == FILTER);
      if (state == FILTER) begin
        oBL_LEVEL  <= levelNext;
        oFRAME_MAX <= snapMax;
        oFRAME_AVG <= avgVal;
      end
    end
  end

  // --- stage: PWM; duty reloads only at the period boundary
  assign preWrap = (preCnt == PRE_W'(PWM_DIV - 1));

  always_ff @(posedge iODCK or negedge iSW1pass0nothing) begin
    if (!iSW1pass0nothing) begin
      preCnt  <= '0;
      phase   <= '0;
      duty    <= 8'(INIT_LEVEL);
      oBL_PWM <= 1'b0;
    end else begin
      oBL_PWM <= (phase < duty);
      if (preWrap) begin
        preCnt <= '0;
        phase  <= phase + 8'd1;
        if (phase == 8'hFF) duty <= oBL_LEVEL;
      end else begin
        preCnt <= preCnt + PRE_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_backlight_level_gen.sv
// Testbench for backlight_level_gen: directed and random frames checked
// against a frame-level arithmetic model of the backlight rules.
module tb_backlight_level_gen;

  localparam int CNT_W   = 5;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int MIN_LV  = 16;
  localparam int KDIV    = 4;   // 2**IIR_SHIFT

  logic        iODCK = 1'b0;
  logic        iSW1pass0nothing;
  logic        iDE;
  logic        iVSYNC;
  logic [23:0] iQE;
  logic [7:0]  oBL_LEVEL;
  logic        oLEVEL_VALID;
  logic [7:0]  oFRAME_MAX;
  logic [7:0]  oFRAME_AVG;
  logic        oBL_PWM;

  int testsRun = 0;
  int failCnt  = 0;
  int modelLevel;
  int frameY[$];

  backlight_level_gen #(
    .CNT_W(CNT_W), .MIN_LEVEL(MIN_LV), .INIT_LEVEL(255), .IIR_SHIFT(2), .PWM_DIV(1)
  ) dut (
    .iODCK            (iODCK),
    .iSW1pass0nothing (iSW1pass0nothing),
    .iDE              (iDE),
    .iVSYNC           (iVSYNC),
    .iQE              (iQE),
    .oBL_LEVEL        (oBL_LEVEL),
    .oLEVEL_VALID     (oLEVEL_VALID),
    .oFRAME_MAX       (oFRAME_MAX),
    .oFRAME_AVG       (oFRAME_AVG),
    .oBL_PWM          (oBL_PWM)
  );

  always #5 iODCK = ~iODCK;

  task automatic step();
    @(posedge iODCK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ymax(input logic [23:0] p);
    int r, g, b;
    r = p[23:16];
    g = p[15:8];
    b = p[7:0];
    if (r >= g && r >= b) return r;
    return (g >= b) ? g : b;
  endfunction

  task automatic pixel(input logic [23:0] p);
    iDE = 1'b1;
    iQE = p;
    frameY.push_back(ymax(p));
    step();
    iDE = 1'b0;
  endtask

  // Frame statistics and the resulting level, from the pixel list of the frame.
  task automatic modelFrame(output int eMax, output int eAvg, output int eCnt);
    int sum, tgt, d, stp;
    sum = 0; eMax = 0; eCnt = 0;
    foreach (frameY[i]) begin
      if (frameY[i] > eMax) eMax = frameY[i];
      if (eCnt < CNT_MAX) begin
        eCnt++;
        sum += frameY[i];
      end
    end
    eAvg = (eCnt != 0) ? sum / eCnt : 0;
    tgt = (3 * eMax + eAvg + 2) / 4;
    if (tgt < MIN_LV) tgt = MIN_LV;
`ifdef BL_IIR_EN
    d = tgt - modelLevel;
    stp = (d >= 0) ? d / KDIV : -((-d + KDIV - 1) / KDIV);
    if (stp == 0 && d != 0) stp = (d > 0) ? 1 : -1;
    modelLevel = modelLevel + stp;
`else
    d = 0; stp = 0;
    modelLevel = tgt + d + stp;
`endif
    frameY.delete();
  endtask

  task automatic endFrame();
    int eMax, eAvg, eCnt, lat;
    bit seen;
    modelFrame(eMax, eAvg, eCnt);
    iDE = 1'b0;
    iVSYNC = 1'b1;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      step();
      lat++;
      if (lat == 1) iVSYNC = 1'b0;
      if (oLEVEL_VALID === 1'b1) seen = 1'b1;
    end
    check("valid_latency", seen ? lat : -1, (eCnt != 0) ? 11 : 3);
    check("level", oBL_LEVEL, modelLevel);
    check("frame_max", oFRAME_MAX, eMax);
    check("frame_avg", oFRAME_AVG, eAvg);
    step();
    check("valid_width", oLEVEL_VALID, 0);
  endtask

  initial begin
    int eMax, eAvg, eCnt, vCount, hi, capLvl, capMax, capAvg, newLvl, n;
    bit found, prev;
    logic [7:0] v;

    iSW1pass0nothing = 1'b0;
    iDE = 1'b0;
    iVSYNC = 1'b0;
    iQE = '0;
    modelLevel = 255;
    repeat (3) step();
    check("rst_level", oBL_LEVEL, 255);
    check("rst_max", oFRAME_MAX, 0);
    check("rst_avg", oFRAME_AVG, 0);
    check("rst_valid", oLEVEL_VALID, 0);
    check("rst_pwm", oBL_PWM, 0);
    iSW1pass0nothing = 1'b1;
    step();

    // Uniform, peak, black and empty frames
    repeat (16) pixel(24'h808080);
    endFrame();
    pixel(24'hFF0000);
    repeat (15) pixel(24'h000000);
    endFrame();
    repeat (16) pixel(24'h000000);
    endFrame();
    endFrame();

    // Count saturation: 40 pixels, only the first CNT_MAX enter sum/count
    for (int i = 0; i < 40; i++) begin
      v = 8'(i * 6);
      pixel({v, v, v});
    end
    endFrame();

    // Random frames
    for (int f = 0; f < 6; f++) begin
      n = $urandom_range(0, 40);
      for (int i = 0; i < n; i++) pixel(24'($urandom()));
      endFrame();
    end

    // Second edge three cycles after the first is dropped and clears the accumulators
    repeat (8) pixel(24'h404040);
    pixel(24'h00C000);
    modelFrame(eMax, eAvg, eCnt);
    iVSYNC = 1'b1; step();
    iVSYNC = 1'b0; iDE = 1'b1; iQE = 24'hFFFFFF; step();
    step();
    iDE = 1'b0; iVSYNC = 1'b1; step();
    iVSYNC = 1'b0;
    vCount = 0; capLvl = -1; capMax = -1; capAvg = -1;
    repeat (30) begin
      step();
      if (oLEVEL_VALID === 1'b1) begin
        vCount++;
        capLvl = oBL_LEVEL; capMax = oFRAME_MAX; capAvg = oFRAME_AVG;
      end
    end
    check("drop_valid_count", vCount, 1);
    check("drop_level", capLvl, modelLevel);
    check("drop_max", capMax, eMax);
    check("drop_avg", capAvg, eAvg);
    repeat (10) pixel(24'h202020);
    endFrame();

    // Reset during DIVIDE (edge E, reset at E+4)
    repeat (10) pixel(24'h606060);
    frameY.delete();
    iVSYNC = 1'b1; step();
    iVSYNC = 1'b0;
    repeat (4) step();
    iSW1pass0nothing = 1'b0;
    #1;
    modelLevel = 255;
    check("midrst_level", oBL_LEVEL, 255);
    check("midrst_max", oFRAME_MAX, 0);
    check("midrst_avg", oFRAME_AVG, 0);
    check("midrst_valid", oLEVEL_VALID, 0);
    check("midrst_pwm", oBL_PWM, 0);
    repeat (3) step();
    iSW1pass0nothing = 1'b1;
    vCount = 0;
    repeat (20) begin
      step();
      if (oLEVEL_VALID === 1'b1) vCount++;
    end
    check("midrst_no_valid", vCount, 0);
    endFrame();

    // PWM: converge on level 64 and measure on-time
    for (int k = 0; k < 20 && modelLevel != 64; k++) begin
      repeat (16) pixel(24'h404040);
      endFrame();
    end
    check("pwm_model_level", modelLevel, 64);
    repeat (600) step();
    hi = 0;
    repeat (256) begin
      step();
      if (oBL_PWM === 1'b1) hi++;
    end
    check("pwm_ontime_64", hi, 64);

    // Level change early in a period only takes effect at the next period
    found = 1'b0;
    prev = oBL_PWM;
    for (int c = 0; c < 600 && !found; c++) begin
      step();
      if (!prev && oBL_PWM === 1'b1) found = 1'b1;
      prev = oBL_PWM;
    end
    check("pwm_rise_found", found, 1);
    modelFrame(eMax, eAvg, eCnt);
    newLvl = modelLevel;
    iVSYNC = 1'b1;
    hi = 1;
    for (int c = 0; c < 300; c++) begin
      step();
      if (c == 0) iVSYNC = 1'b0;
      if (oBL_PWM !== 1'b1) break;
      hi++;
    end
    check("pwm_old_duty_kept", hi, 64);
    check("pwm_new_level", oBL_LEVEL, newLvl);
    found = 1'b0;
    prev = oBL_PWM;
    for (int c = 0; c < 300 && !found; c++) begin
      step();
      if (!prev && oBL_PWM === 1'b1) found = 1'b1;
      prev = oBL_PWM;
    end
    check("pwm_rise2_found", found, 1);
    hi = 1;
    for (int c = 0; c < 300; c++) begin
      step();
      if (oBL_PWM !== 1'b1) break;
      hi++;
    end
    check("pwm_new_duty", hi, newLvl);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCnt);
    $finish;
  end

endmodule
